// File: rtl/cke_generator.sv
// cke_generator
//
// Multi-channel clock-enable generator. Every channel has a programmable
// down-counter that produces two outputs:
//   - a one-cycle enable pulse once per period
//   - a duty-cycle level output
// With the default settings each channel reproduces the 68000 E-clock divider:
// divide-by-10, 6 cycles low then 4 cycles high, with en on the last high cycle.
//
// Configuration is shadowed. A write lands in pend_div/pend_high, and the
// channel copies it into act_div/act_high only when its counter wraps
// (cnt == 0) or when resync is pulsed. A period in progress is therefore
// never disturbed.
//
// Optional feature (compile-time macro CKE_HOLD_EN):
//   defined   - hold[i] freezes channel i (counter, active config, wrap load).
//               resync still reloads a held channel.
//   undefined - hold is accepted but ignored.
//
// Parameters:
//   NUM_CH       number of channels (1..8)
//   DIV_W        counter / configuration width
//   DEFAULT_DIV  reset period in clk cycles (2..2^DIV_W-1)
//   DEFAULT_HIGH reset high time of lvl
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous reset, active high
//   cfg_wr    configuration write strobe
//   cfg_ch    target channel of cfg_wr (out-of-range indices are ignored)
//   cfg_div   new period; 0 disables the channel
//   cfg_high  new high time of lvl
//   resync    realign every channel to the start of its period
//   hold      per-channel freeze (only with CKE_HOLD_EN)
//   en        per-channel one-cycle enable pulse
//   lvl       per-channel duty-cycle level
//   cnt       flattened counters, channel i at [i*DIV_W +: DIV_W]

module cke_generator #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned DEFAULT_DIV  = 10,
  parameter int unsigned DEFAULT_HIGH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_wr,
  input  logic [2:0]              cfg_ch,
  input  logic [DIV_W-1:0]        cfg_div,
  input  logic [DIV_W-1:0]        cfg_high,
  input  logic                    resync,
  input  logic [NUM_CH-1:0]       hold,
  output logic [NUM_CH-1:0]       en,
  output logic [NUM_CH-1:0]       lvl,
  output logic [NUM_CH*DIV_W-1:0] cnt
);

  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] RST_HIGH = DIV_W'(DEFAULT_HIGH);
  localparam logic [DIV_W-1:0] RST_CNT  = DIV_W'(DEFAULT_DIV - 1);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  // Channels whose counter does not advance this cycle. resync always wins.
  logic [NUM_CH-1:0] frozen;

`ifdef CKE_HOLD_EN
  assign frozen = hold & ~{NUM_CH{resync}};
`else
  logic unused_hold;
  assign unused_hold = ^hold;
  assign frozen      = '0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] pend_div_q;
    logic [DIV_W-1:0] pend_high_q;
    logic [DIV_W-1:0] act_div_q;
    logic [DIV_W-1:0] act_high_q;
    logic [DIV_W-1:0] cnt_q;

    logic             sel;
    logic             wrap;
    logic             load;
    logic [DIV_W-1:0] nxt_div;
    logic [DIV_W-1:0] nxt_high;
    logic [DIV_W-1:0] load_cnt;

    // i < NUM_CH <= 8, so a match also means cfg_ch is in range.
    assign sel = cfg_wr && (cfg_ch == 3'(i));

    // A write in the same cycle as a wrap or resync is seen by that load.
    assign nxt_div  = sel ? cfg_div  : pend_div_q;
    assign nxt_high = sel ? cfg_high : pend_high_q;

    // A disabled channel sits at cnt == 0, so it polls pend_div every cycle.
    assign wrap     = (cnt_q == '0);
    assign load     = resync || (wrap && !frozen[i]);
    assign load_cnt = (nxt_div == '0) ? '0 : (nxt_div - ONE);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pend_div_q  <= RST_DIV;
        pend_high_q <= RST_HIGH;
        act_div_q   <= RST_DIV;
        act_high_q  <= RST_HIGH;
        cnt_q       <= RST_CNT;
      end else begin
        pend_div_q  <= nxt_div;
        pend_high_q <= nxt_high;
        if (load) begin
          act_div_q  <= nxt_div;
          act_high_q <= nxt_high;
          cnt_q      <= load_cnt;
        end else if (!frozen[i]) begin
          cnt_q <= cnt_q - ONE;
        end
      end
    end

    // Pure register decodes; no input reaches the outputs combinationally.
    assign en[i]                  = wrap && (act_div_q != '0);
    assign lvl[i]                 = (act_div_q != '0) && (cnt_q < act_high_q);
    assign cnt[i*DIV_W +: DIV_W]  = cnt_q;
  end

endmodule

// File: doc/cke_generator.md
Name: cke_generator

Overview:
- Multi-channel clock-enable generator. All channels run in the single system clock domain.
- Each channel produces a one-cycle enable pulse and a duty-cycle level output. Both are derived from a programmable down-counter.
- Generalises the fixed 68000 E-clock divider (divide-by-10, 6 low / 4 high) to NUM_CH channels with runtime-programmable period and high time.
- Has a global resync and shadowed configuration. Feeds CIA timers, audio/floppy strobes and the E-clock to the CPU interface.

Parameters:
- NUM_CH, 4, number of independent enable channels (1..8)
- DIV_W, 8, counter and configuration width in bits
- DEFAULT_DIV, 10, reset period of every channel in clk cycles (must be 2..2^DIV_W-1)
- DEFAULT_HIGH, 4, reset high time of every channel's level output

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous reset, active high
- cfg_wr  in  1  configuration write strobe
- cfg_ch  in  3  channel index for cfg_wr
- cfg_div  in  DIV_W  new period; 0 disables the channel
- cfg_high  in  DIV_W  new high time in cycles
- resync  in  1  realign all channels to period start
- hold  in  NUM_CH  per-channel counter freeze (see Optional Feature)
- en  out  NUM_CH  one-cycle enable pulse per period
- lvl  out  NUM_CH  duty-cycle level output
- cnt  out  NUM_CH*DIV_W  flattened current counter values; channel i occupies bits [i*DIV_W +: DIV_W]

Behaviour:
- Per-channel registers: pend_div, pend_high (shadow), act_div, act_high (active), cnt.
- Reset:
  - pend_div and act_div = DEFAULT_DIV; pend_high and act_high = DEFAULT_HIGH; cnt = DEFAULT_DIV-1.
  - Consequently en = 0 and lvl = 0 during and immediately after reset.
- Outputs are pure decodes of registers, with no combinational path from inputs:
  - en[i] = (cnt==0) && (act_div!=0)
  - lvl[i] = (act_div!=0) && (cnt < act_high)
- Counter, each clk when not frozen:
  - If cnt==0: act_div <= pend_div, act_high <= pend_high, cnt <= pend_div-1 (or 0 if pend_div==0).
  - Else: cnt <= cnt-1.
- Period:
  - en pulses once every act_div cycles.
  - lvl is low for act_div-act_high cycles, then high for act_high cycles, ending in the en cycle.
  - Defaults give 6 low / 4 high with en on the last high cycle.
- Configuration writes:
  - cfg_wr updates pend_* of channel cfg_ch only. The new value takes effect at that channel's next wrap (cnt==0), never mid-period.
  - cfg_ch >= NUM_CH: the write is ignored.
- act_div==0 (disabled): cnt held at 0, en=0, lvl=0. A pending nonzero div is picked up on the next clk because cnt==0.
- act_div==1: en asserted every cycle; lvl=1 if act_high>=1.
- act_high >= act_div: lvl constantly 1 while enabled. act_high==0: lvl constantly 0.
- Resync:
  - Every channel copies pend_* to act_* and sets cnt <= pend_div-1 (0 if disabled) on the next edge, regardless of its current count.
  - First en after resync occurs pend_div cycles later.
- cfg_wr and resync in the same cycle: the written value is used by the resync load.
- cfg_wr and wrap on the same channel in the same cycle: the wrap loads the newly written value.
- Reset asserted mid-period: immediate return to reset values, with no partial en pulse.

Optional Feature:
- Macro CKE_HOLD_EN.
- Defined:
  - hold[i]=1 freezes channel i: cnt, act_* and the wrap load are all frozen. en and lvl keep their decoded values, so an en asserted in a held cycle stays asserted.
  - resync overrides hold.
- Undefined: the hold port exists but is ignored; counters never freeze.

Test Plan:
- Reset release, no config -> every channel: en pulses every 10 cycles; lvl low 6 / high 4; en coincides with the 4th high cycle; cnt sequence 9..0.
- cfg_wr ch1 div=3 high=1 at mid-period (cnt=5) -> ch1 completes cnt 4..0 unchanged, then en every 3 cycles, lvl high only on the en cycle; other channels unaffected.
- cfg_wr ch2 div=0 -> after the current wrap, en[2]=0, lvl[2]=0, cnt[2]=0. Then write div=2 high=2 -> en[2] every 2nd cycle and lvl[2]=1 constant, starting within 2 cycles.
- Channels at differing counts, resync pulse -> next cycle all cnt=DEFAULT_DIV-1; first en for all channels exactly 10 cycles after resync.
- Simultaneous resync and cfg_wr ch0 div=5 -> ch0 cnt=4 next cycle; en[0] every 5 cycles.
- With CKE_HOLD_EN: hold[3]=1 for 7 cycles starting at cnt=2 -> cnt[3] stays 2 and the en[3] period stretches to 17. Without the macro: same stimulus, period remains 10.
